// File: rtl/compare_pkg.sv
// rtl/compare_pkg.sv - shared constants for the streaming magnitude comparator
// Purpose: frame FSM state encoding and one-hot result codes {gt, lt, eq}.
// Ports: none (package).
package compare_pkg;

  // Frame FSM: IDLE before any frame, ACC while a frame is open, DONE after it closes
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // One-hot result ordering matches the output bits {xgy, xsy, xey}
  localparam logic [2:0] RES_GT = 3'b100;
  localparam logic [2:0] RES_LT = 3'b010;
  localparam logic [2:0] RES_EQ = 3'b001;

endpackage

// File: rtl/compare_stream_if.sv
// rtl/compare_stream_if.sv - pair intake, result output and frame statistics bundle
// Purpose: groups the compare_stream handshake and data signals.
// Ports (modport slave = comparator side, master = source/consumer side):
//   in_valid/in_ready/x/y/signed_mode/in_last : pair intake
//   out_valid/out_ready/xgy/xsy/xey           : per-pair result
//   stat_valid/max_x/min_x/gt_cnt/eq_cnt/lt_cnt : published frame statistics
interface compare_stream_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             signed_mode;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic             xgy;
  logic             xsy;
  logic             xey;
  logic             stat_valid;
  logic [WIDTH-1:0] max_x;
  logic [WIDTH-1:0] min_x;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;

  modport slave (
    input  in_valid, x, y, signed_mode, in_last, out_ready,
    output in_ready, out_valid, xgy, xsy, xey,
    output stat_valid, max_x, min_x, gt_cnt, eq_cnt, lt_cnt
  );

  modport master (
    output in_valid, x, y, signed_mode, in_last, out_ready,
    input  in_ready, out_valid, xgy, xsy, xey,
    input  stat_valid, max_x, min_x, gt_cnt, eq_cnt, lt_cnt
  );
endinterface

// File: rtl/compare_core.sv
// rtl/compare_core.sv - combinational signed/unsigned magnitude compare
// Purpose: compares a against b in WIDTH+1 bits so neither mode can overflow.
// Ports:
//   a, b      in  WIDTH  operands
//   is_signed in  1      1 = two's complement, 0 = unsigned
//   gt/lt/eq  out 1      a>b / a<b / a==b (exactly one is set)
module compare_core #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  // The extra top bit is the sign copy in signed mode and zero otherwise,
  // so one signed compare serves both modes.
  logic signed [WIDTH:0] a_ext;
  logic signed [WIDTH:0] b_ext;

  assign a_ext = {is_signed & a[WIDTH-1], a};
  assign b_ext = {is_signed & b[WIDTH-1], b};

  assign gt = (a_ext > b_ext);
  assign lt = (a_ext < b_ext);
  assign eq = (a == b);

endmodule

// File: rtl/compare_stream.sv
// rtl/compare_stream.sv - streaming 3-way comparator with per-frame statistics
// Purpose: registers a one-hot compare result per accepted (x,y) pair and
//   publishes max/min of x and gt/eq/lt counts when a frame closes on in_last.
// Ports:
//   clk  in  1  rising-edge clock
//   rst  in  1  synchronous active-high reset
//   bus  compare_stream_if.slave  intake, result and statistics signals
module compare_stream
  import compare_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  compare_stream_if.slave        bus
);

  logic [1:0]       state;
  logic             mode_q;
  logic             out_valid_q;
  logic [2:0]       res_q;
  logic [WIDTH-1:0] run_max, run_min;
  logic [CNT_W-1:0] run_gt, run_eq, run_lt;
  logic [WIDTH-1:0] pub_max, pub_min;
  logic [CNT_W-1:0] pub_gt, pub_eq, pub_lt;

  logic             acc;
  logic             first;
  logic             mode_eff;
  logic             gt_xy, lt_xy, eq_xy;
  logic             x_gt_max, x_lt_min;
  logic             unused_max_lt, unused_max_eq, unused_min_gt, unused_min_eq;
  logic [WIDTH-1:0] nxt_max, nxt_min;
  logic [CNT_W-1:0] nxt_gt, nxt_eq, nxt_lt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign acc          = bus.in_valid && bus.in_ready;

  // Any acc outside ACC opens a new frame and samples its compare mode.
  assign first    = (state != ST_ACC);
  assign mode_eff = first ? bus.signed_mode : mode_q;

  compare_core #(.WIDTH(WIDTH)) u_cmp_xy (
    .a(bus.x), .b(bus.y), .is_signed(mode_eff),
    .gt(gt_xy), .lt(lt_xy), .eq(eq_xy)
  );

  compare_core #(.WIDTH(WIDTH)) u_cmp_max (
    .a(bus.x), .b(run_max), .is_signed(mode_eff),
    .gt(x_gt_max), .lt(unused_max_lt), .eq(unused_max_eq)
  );

  compare_core #(.WIDTH(WIDTH)) u_cmp_min (
    .a(bus.x), .b(run_min), .is_signed(mode_eff),
    .gt(unused_min_gt), .lt(x_lt_min), .eq(unused_min_eq)
  );

  // Working accumulators after this pair; also what gets published on in_last.
  always_comb begin
    nxt_max = run_max;
    nxt_min = run_min;
    nxt_gt  = run_gt;
    nxt_eq  = run_eq;
    nxt_lt  = run_lt;
    if (first) begin
      nxt_max = bus.x;
      nxt_min = bus.x;
      nxt_gt  = CNT_W'(gt_xy);
      nxt_eq  = CNT_W'(eq_xy);
      nxt_lt  = CNT_W'(lt_xy);
    end else begin
      if (x_gt_max) nxt_max = bus.x;
      if (x_lt_min) nxt_min = bus.x;
      nxt_gt = sat_inc(run_gt, gt_xy);
      nxt_eq = sat_inc(run_eq, eq_xy);
      nxt_lt = sat_inc(run_lt, lt_xy);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      res_q       <= 3'b000;
      run_max     <= '0;
      run_min     <= '0;
      run_gt      <= '0;
      run_eq      <= '0;
      run_lt      <= '0;
      pub_max     <= '0;
      pub_min     <= '0;
      pub_gt      <= '0;
      pub_eq      <= '0;
      pub_lt      <= '0;
    end else begin
      // A new acc overwrites the single output entry even while it transfers.
      if (acc) begin
        out_valid_q <= 1'b1;
        res_q       <= gt_xy ? RES_GT : (lt_xy ? RES_LT : RES_EQ);
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (acc) begin
        if (first) mode_q <= bus.signed_mode;
        run_max <= nxt_max;
        run_min <= nxt_min;
        run_gt  <= nxt_gt;
        run_eq  <= nxt_eq;
        run_lt  <= nxt_lt;
        state   <= bus.in_last ? ST_DONE : ST_ACC;
        if (bus.in_last) begin
          pub_max <= nxt_max;
          pub_min <= nxt_min;
          pub_gt  <= nxt_gt;
          pub_eq  <= nxt_eq;
          pub_lt  <= nxt_lt;
        end
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.xgy        = res_q[2];
  assign bus.xsy        = res_q[1];
  assign bus.xey        = res_q[0];
  assign bus.stat_valid = (state == ST_DONE);
  assign bus.max_x      = pub_max;
  assign bus.min_x      = pub_min;
  assign bus.gt_cnt     = pub_gt;
  assign bus.eq_cnt     = pub_eq;
  assign bus.lt_cnt     = pub_lt;

endmodule

// File: tb/tb_compare_stream.sv
// tb/tb_compare_stream.sv - scoreboard bench for compare_stream (WIDTH=3, CNT_W=2)
module tb_compare_stream;

  localparam int W = 3;
  localparam int C = 2;
  localparam int CMAX = (1 << C) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   rand_ready = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  compare_stream_if #(.WIDTH(W), .CNT_W(C)) bus ();

  compare_stream #(.WIDTH(W), .CNT_W(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference state: pending results and the frame being gathered.
  logic [2:0] q[$];
  bit         m_open = 1'b0;
  bit         m_mode = 1'b0;
  int         fx[$];
  int         cg = 0, ce = 0, cl = 0;
  int         e_sv = 0, e_max = 0, e_min = 0, e_gt = 0, e_eq = 0, e_lt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int val(input logic [W-1:0] v, input bit s);
    return (s && v[W-1]) ? int'(v) - (1 << W) : int'(v);
  endfunction

  task automatic model_accept();
    int vx, vy, mx, mn;
    if (!m_open) begin
      m_open = 1'b1;
      m_mode = bus.signed_mode;
      fx.delete();
      cg = 0; ce = 0; cl = 0;
    end
    vx = val(bus.x, m_mode);
    vy = val(bus.y, m_mode);
    if (vx > vy) begin q.push_back(3'b100); cg++; end
    else if (vx < vy) begin q.push_back(3'b010); cl++; end
    else begin q.push_back(3'b001); ce++; end
    fx.push_back(vx);
    if (bus.in_last) begin
      mx = fx[0]; mn = fx[0];
      foreach (fx[i]) begin
        if (fx[i] > mx) mx = fx[i];
        if (fx[i] < mn) mn = fx[i];
      end
      e_sv  = 1;
      e_max = mx & ((1 << W) - 1);
      e_min = mn & ((1 << W) - 1);
      e_gt  = (cg > CMAX) ? CMAX : cg;
      e_eq  = (ce > CMAX) ? CMAX : ce;
      e_lt  = (cl > CMAX) ? CMAX : cl;
      m_open = 1'b0;
    end else begin
      e_sv = 0;
    end
  endtask

  // Monitor: compares everything the DUT shows, then advances the model by
  // what the coming rising edge will do.
  initial begin
    bit m_rdy;
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("stat_valid", bus.stat_valid, e_sv);
      chk("max_x", bus.max_x, e_max);
      chk("min_x", bus.min_x, e_min);
      chk("gt_cnt", bus.gt_cnt, e_gt);
      chk("eq_cnt", bus.eq_cnt, e_eq);
      chk("lt_cnt", bus.lt_cnt, e_lt);
      chk("out_valid", bus.out_valid, int'(q.size() != 0));
      m_rdy = (q.size() == 0) || bus.out_ready;
      chk("in_ready", bus.in_ready, m_rdy);
      if (q.size() != 0) chk("result", {bus.xgy, bus.xsy, bus.xey}, q[0]);
      if (rst) begin
        q.delete();
        m_open = 1'b0;
        e_sv = 0; e_max = 0; e_min = 0; e_gt = 0; e_eq = 0; e_lt = 0;
      end else begin
        if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && m_rdy) model_accept();
      end
    end
  end

  task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic sm, input logic last);
    bus.x = xv; bus.y = yv; bus.signed_mode = sm; bus.in_last = last;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    tests++; fails++;
    $display("FAIL send_timeout: in_ready never rose for x=%0d y=%0d", xv, yv);
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.x = '0; bus.y = '0;
    bus.signed_mode = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Unsigned three-pair frame
    send(3'd5, 3'd3, 1'b0, 1'b0);
    send(3'd3, 3'd3, 1'b0, 1'b0);
    send(3'd2, 3'd6, 1'b0, 1'b1);
    idle(2);
    chk("t1_max", bus.max_x, 5); chk("t1_min", bus.min_x, 2);
    chk("t1_gt", bus.gt_cnt, 1); chk("t1_eq", bus.eq_cnt, 1); chk("t1_lt", bus.lt_cnt, 1);

    // -1 vs 1 signed, then the same bits unsigned
    send(3'b111, 3'b001, 1'b1, 1'b1);
    idle(2);
    chk("t2_max", bus.max_x, 7); chk("t2_min", bus.min_x, 7); chk("t2_lt", bus.lt_cnt, 1);
    send(3'b111, 3'b001, 1'b0, 1'b1);
    idle(2);
    chk("t2u_gt", bus.gt_cnt, 1);

    // Backpressure, then transfer and accept in the same cycle
    bus.out_ready = 1'b0;
    send(3'd1, 3'd2, 1'b0, 1'b0);
    bus.x = 3'd4; bus.y = 3'd0; bus.in_last = 1'b1; bus.in_valid = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_hold_xsy", bus.xsy, 1);
    end
    bus.out_ready = 1'b1;
    send(3'd4, 3'd0, 1'b0, 1'b1);
    idle(2);

    // Mode latched at frame start
    send(3'b111, 3'b001, 1'b1, 1'b0);
    send(3'b111, 3'b001, 1'b0, 1'b0);
    send(3'b100, 3'b011, 1'b0, 1'b1);
    idle(2);
    chk("t4_lt", bus.lt_cnt, 3); chk("t4_min", bus.min_x, 4); chk("t4_max", bus.max_x, 7);

    // Counter saturation
    repeat (5) send(3'd2, 3'd2, 1'b0, 1'b0);
    send(3'd2, 3'd2, 1'b0, 1'b1);
    idle(2);
    chk("t5_eq", bus.eq_cnt, 3); chk("t5_gt", bus.gt_cnt, 0); chk("t5_lt", bus.lt_cnt, 0);

    // Reset mid-frame
    send(3'd1, 3'd0, 1'b0, 1'b0);
    send(3'd0, 3'd1, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk("t6_out_valid", bus.out_valid, 0); chk("t6_stat_valid", bus.stat_valid, 0);
    chk("t6_max", bus.max_x, 0);
    send(3'd6, 3'd6, 1'b0, 1'b1);
    idle(2);
    chk("t6_eq", bus.eq_cnt, 1); chk("t6_gt", bus.gt_cnt, 0); chk("t6_max2", bus.max_x, 6);

    // Randomized traffic with random consumer stalls
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(W'($urandom_range(0, 7)), W'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 4) == 0) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    rand_ready = 1'b0;
    idle(4);
    chk("drained", q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
